mac_mdc_tile_sched: RTL and testbench

Tile scheduler in front of the MAC MDC HWPE controller. It accepts one job descriptor: four base addresses for streams a/b/c/d, four per-tile address strides, and a tile count. It then issues one start handshake per tile to the HWPE control FSM, waits for each tile's done, advances the addresses, and pulses an end-of-job event. It replaces software-driven per-tile restarts between the slave register file and the HWPE FSM.

---
 rtl/mac_mdc_tile_sched.sv | 130 +++++++++++++
 tb/tb_mac_mdc_tile_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_mdc_tile_sched.sv
// rtl/mac_mdc_tile_sched.sv - per-tile start/done sequencer for the MAC MDC HWPE controller.
// Optional watchdog: define MAC_MDC_TILE_SCHED_WATCHDOG_EN.
module mac_mdc_tile_sched #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic                job_valid_i,
  output logic                job_ready_o,
  input  logic [4*ADDR_W-1:0] job_addr_i,
  input  logic [4*ADDR_W-1:0] job_stride_i,
  input  logic [CNT_W-1:0]    job_ntiles_i,
  output logic                tile_start_o,
  input  logic                tile_ready_i,
  output logic [4*ADDR_W-1:0] tile_addr_o,
  output logic [CNT_W-1:0]    tile_idx_o,
  input  logic                tile_done_i,
  output logic                busy_o,
  output logic                evt_o,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, RUN, FINISH} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q   [4];
  logic [ADDR_W-1:0] stride_q [4];
  logic [CNT_W-1:0]  ntiles_q, idx_q;
  logic              last_tile;
  logic              timeout;
  logic              accept;
  logic              advance;

  assign last_tile = (idx_q == ntiles_q - CNT_W'(1));
  assign accept    = (state_q == IDLE) && job_valid_i;
  assign advance   = (state_q == RUN) && tile_done_i && !last_tile;

`ifdef MAC_MDC_TILE_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            err_q;

  // A done arriving in the timeout cycle wins, so timeout alone never masks it.
  assign timeout = (state_q == RUN) && (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else if (clear_i) begin
      wd_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state_q == ISSUE && tile_ready_i) wd_cnt_q <= '0;
      else if (state_q == RUN)              wd_cnt_q <= wd_cnt_q + WD_W'(1);
      if (accept)                           err_q <= 1'b0;
      else if (timeout && !tile_done_i)     err_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (job_valid_i) state_d = (job_ntiles_i == '0) ? FINISH : ISSUE;
      ISSUE:   if (tile_ready_i) state_d = RUN;
      RUN: begin
        if (tile_done_i)  state_d = last_tile ? FINISH : ISSUE;
        else if (timeout) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ntiles_q <= '0;
      idx_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        addr_q[k]   <= '0;
        stride_q[k] <= '0;
      end
    end else if (clear_i) begin
      state_q  <= IDLE;
      ntiles_q <= '0;
      idx_q    <= '0;
      for (int k = 0; k < 4; k++) begin
        addr_q[k]   <= '0;
        stride_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (accept) begin
        ntiles_q <= job_ntiles_i;
        idx_q    <= '0;
        for (int k = 0; k < 4; k++) begin
          addr_q[k]   <= job_addr_i[k*ADDR_W +: ADDR_W];
          stride_q[k] <= job_stride_i[k*ADDR_W +: ADDR_W];
        end
      end else if (advance) begin
        idx_q <= idx_q + CNT_W'(1);
        // Modular add: a two's-complement stride walks addresses downward.
        for (int k = 0; k < 4; k++) addr_q[k] <= addr_q[k] + stride_q[k];
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_addr
    assign tile_addr_o[g*ADDR_W +: ADDR_W] = addr_q[g];
  end

  assign job_ready_o  = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign tile_start_o = (state_q == ISSUE);
  assign evt_o        = (state_q == FINISH);
  assign tile_idx_o   = idx_q;

endmodule

// File: tb/tb_mac_mdc_tile_sched.sv
// tb/tb_mac_mdc_tile_sched.sv - directed self-checking bench for mac_mdc_tile_sched.
module tb_mac_mdc_tile_sched;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         clear_i = 1'b0;
  logic         job_valid_i = 1'b0;
  logic         job_ready_o;
  logic [127:0] job_addr_i = '0;
  logic [127:0] job_stride_i = '0;
  logic [15:0]  job_ntiles_i = '0;
  logic         tile_start_o;
  logic         tile_ready_i = 1'b0;
  logic [127:0] tile_addr_o;
  logic [15:0]  tile_idx_o;
  logic         tile_done_i = 1'b0;
  logic         busy_o;
  logic         evt_o;
  logic         err_o;

  int errors = 0;
  int checks = 0;
  int evt_cnt = 0;

  mac_mdc_tile_sched #(.ADDR_W(32), .CNT_W(16), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
    .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
    .job_addr_i(job_addr_i), .job_stride_i(job_stride_i), .job_ntiles_i(job_ntiles_i),
    .tile_start_o(tile_start_o), .tile_ready_i(tile_ready_i),
    .tile_addr_o(tile_addr_o), .tile_idx_o(tile_idx_o), .tile_done_i(tile_done_i),
    .busy_o(busy_o), .evt_o(evt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) if (evt_o) evt_cnt++;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Drives the descriptor for one cycle; returns one cycle after the accept.
  task automatic accept(input logic [127:0] a, input logic [127:0] s, input logic [15:0] n);
    job_addr_i   = a;
    job_stride_i = s;
    job_ntiles_i = n;
    job_valid_i  = 1'b1;
    step();
    job_valid_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) step();
    checks++;
    if ({job_ready_o, busy_o, tile_start_o, evt_o, err_o} !== 5'b10000) begin
      errors++; $display("FAIL reset_flags: got %b want 10000", {job_ready_o, busy_o, tile_start_o, evt_o, err_o});
    end
    checks++;
    if ({tile_addr_o, tile_idx_o} !== 144'h0) begin
      errors++; $display("FAIL reset_addr_idx: got %h/%h want 0/0", tile_addr_o, tile_idx_o);
    end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_three_tiles();
    int e0 = evt_cnt;
    logic [31:0] exp_a;
    tile_ready_i = 1'b1;
    accept({32'h4000, 32'h3000, 32'h2000, 32'h1000}, {96'h0, 32'h40}, 16'd3);
    for (int t = 0; t < 3; t++) begin
      exp_a = 32'h1000 + 32'h40 * t;
      checks++;
      if (tile_start_o !== 1'b1 || tile_addr_o[31:0] !== exp_a) begin
        errors++; $display("FAIL three_start_addr%0d: got start=%b a=%h want 1 a=%h", t, tile_start_o, tile_addr_o[31:0], exp_a);
      end
      checks++;
      if (tile_idx_o !== 16'(t) || tile_addr_o[127:32] !== {32'h4000, 32'h3000, 32'h2000}) begin
        errors++; $display("FAIL three_idx_bcd%0d: got idx=%0d bcd=%h want %0d", t, tile_idx_o, tile_addr_o[127:32], t);
      end
      repeat (5) step();
      tile_done_i = 1'b1;
      step();
      tile_done_i = 1'b0;
    end
    checks++;
    if (evt_o !== 1'b1 || job_ready_o !== 1'b0) begin
      errors++; $display("FAIL three_evt: got evt=%b ready=%b want 1 0", evt_o, job_ready_o);
    end
    step();
    checks++;
    if (job_ready_o !== 1'b1 || evt_cnt - e0 !== 1) begin
      errors++; $display("FAIL three_end: got ready=%b evts=%0d want 1 1", job_ready_o, evt_cnt - e0);
    end
  endtask

  task automatic test_zero_tiles();
    accept({4{32'h1234}}, '0, 16'd0);
    checks++;
    if ({tile_start_o, evt_o, job_ready_o} !== 3'b010) begin
      errors++; $display("FAIL zero_accept1: got start/evt/ready=%b want 010", {tile_start_o, evt_o, job_ready_o});
    end
    step();
    checks++;
    if ({evt_o, job_ready_o} !== 2'b01) begin
      errors++; $display("FAIL zero_accept2: got evt/ready=%b want 01", {evt_o, job_ready_o});
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] exp = {32'hD000, 32'hC000, 32'hB000, 32'hA000};
    tile_ready_i = 1'b0;
    accept(exp, {4{32'h100}}, 16'd1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tile_start_o !== 1'b1 || tile_addr_o !== exp) begin
        errors++; $display("FAIL bp_hold%0d: got start=%b addr=%h want 1 %h", i, tile_start_o, tile_addr_o, exp);
      end
      tile_done_i  = (i == 1);
      tile_ready_i = (i == 3);
      step();
    end
    tile_ready_i = 1'b0;
    tile_done_i  = 1'b0;
    repeat (2) step();
    checks++;
    if ({tile_start_o, evt_o, busy_o} !== 3'b001) begin
      errors++; $display("FAIL bp_run: got start/evt/busy=%b want 001", {tile_start_o, evt_o, busy_o});
    end
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    checks++;
    if (evt_o !== 1'b1) begin
      errors++; $display("FAIL bp_evt: got %b want 1", evt_o);
    end
    step();
  endtask

  task automatic test_wrap();
    tile_ready_i = 1'b1;
    accept({32'hFFFF_FFC0, 96'h0}, {32'h80, 96'h0}, 16'd2);
    checks++;
    if (tile_addr_o[127:96] !== 32'hFFFF_FFC0) begin
      errors++; $display("FAIL wrap_first: got %h want ffffffc0", tile_addr_o[127:96]);
    end
    step();
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    checks++;
    if (tile_addr_o[127:96] !== 32'h0000_0040 || tile_idx_o !== 16'd1 || tile_start_o !== 1'b1) begin
      errors++; $display("FAIL wrap_second: got d=%h idx=%0d start=%b want 00000040 1 1", tile_addr_o[127:96], tile_idx_o, tile_start_o);
    end
    step();
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    checks++;
    if (evt_o !== 1'b1) begin
      errors++; $display("FAIL wrap_evt: got %b want 1", evt_o);
    end
    step();
    checks++;
    if (job_ready_o !== 1'b1) begin
      errors++; $display("FAIL wrap_min_time: got ready=%b want 1", job_ready_o);
    end
  endtask

  task automatic test_clear();
    int e0;
    tile_ready_i = 1'b1;
    accept({96'h0, 32'h5000}, {96'h0, 32'h10}, 16'd4);
    step();
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    step();
    checks++;
    if (tile_idx_o !== 16'd1 || {busy_o, tile_start_o} !== 2'b10) begin
      errors++; $display("FAIL clear_pre: got idx=%0d busy/start=%b want 1 10", tile_idx_o, {busy_o, tile_start_o});
    end
    e0 = evt_cnt;
    clear_i     = 1'b1;
    tile_done_i = 1'b1;
    step();
    clear_i     = 1'b0;
    tile_done_i = 1'b0;
    checks++;
    if ({job_ready_o, evt_o} !== 2'b10 || tile_idx_o !== 16'd0 || tile_addr_o !== 128'h0) begin
      errors++; $display("FAIL clear_idle: got ready/evt=%b idx=%0d addr=%h want 10 0 0", {job_ready_o, evt_o}, tile_idx_o, tile_addr_o);
    end
    step();
    checks++;
    if (evt_cnt !== e0) begin
      errors++; $display("FAIL clear_no_evt: got %0d evts want 0", evt_cnt - e0);
    end
    accept({96'h0, 32'h7000}, '0, 16'd1);
    checks++;
    if (tile_start_o !== 1'b1 || tile_idx_o !== 16'd0 || tile_addr_o[31:0] !== 32'h7000) begin
      errors++; $display("FAIL clear_restart: got start=%b idx=%0d a=%h want 1 0 7000", tile_start_o, tile_idx_o, tile_addr_o[31:0]);
    end
    step();
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    checks++;
    if (evt_o !== 1'b1) begin
      errors++; $display("FAIL clear_restart_evt: got %b want 1", evt_o);
    end
    step();
  endtask

  task automatic test_async_reset();
    tile_ready_i = 1'b0;
    accept({4{32'hCAFE}}, '0, 16'd2);
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({job_ready_o, tile_start_o, busy_o} !== 3'b100 || tile_addr_o !== 128'h0) begin
      errors++; $display("FAIL async_reset: got ready/start/busy=%b addr=%h want 100 0", {job_ready_o, tile_start_o, busy_o}, tile_addr_o);
    end
    step();
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_watchdog();
    tile_ready_i = 1'b1;
    accept('0, '0, 16'd2);
    step();
`ifdef MAC_MDC_TILE_SCHED_WATCHDOG_EN
    repeat (15) step();
    checks++;
    if ({evt_o, err_o} !== 2'b00) begin
      errors++; $display("FAIL wd_early: got evt/err=%b want 00", {evt_o, err_o});
    end
    step();
    checks++;
    if ({evt_o, err_o} !== 2'b11) begin
      errors++; $display("FAIL wd_fire: got evt/err=%b want 11", {evt_o, err_o});
    end
    step();
    checks++;
    if ({job_ready_o, err_o} !== 2'b11) begin
      errors++; $display("FAIL wd_sticky: got ready/err=%b want 11", {job_ready_o, err_o});
    end
    accept('0, '0, 16'd1);
    checks++;
    if (err_o !== 1'b0) begin
      errors++; $display("FAIL wd_clear_on_accept: got %b want 0", err_o);
    end
    step();
    tile_done_i = 1'b1;
    step();
    tile_done_i = 1'b0;
    step();
`else
    repeat (40) step();
    checks++;
    if ({busy_o, err_o, tile_start_o, evt_o} !== 4'b1000) begin
      errors++; $display("FAIL nowd_wait: got busy/err/start/evt=%b want 1000", {busy_o, err_o, tile_start_o, evt_o});
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    checks++;
    if (job_ready_o !== 1'b1) begin
      errors++; $display("FAIL nowd_clear: got ready=%b want 1", job_ready_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_three_tiles();
    test_zero_tiles();
    test_backpressure();
    test_wrap();
    test_clear();
    test_async_reset();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
